fp_cdb_arbiter: RTL

Arbitrates the single FP common data bus (`we_FP`/`tag_FP`/`val_FP` broadcast snooped by the FP reservation stations and the register file) among NREQ FP result producers (add/sub pipe, multiply pipe, divide unit).
- Each producer owns a one-entry holding register.
- Exactly one held result is granted per cycle, round-robin, and driven onto a registered broadcast.
- Producers are back-pressured with a valid/ready handshake.

---
 rtl/fp_cdb_arbiter_pkg.sv | 24 ++
 rtl/fp_cdb_arbiter_if.sv | 42 ++++
 rtl/fp_cdb_arbiter_rr_pick.sv | 37 +++
 rtl/fp_cdb_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp_cdb_arbiter_pkg.sv
// Shared FP definitions: default field widths common with the FP reservation
// stations, the CDB bundle layout and a small round-robin helper.
package fp_cdb_arbiter_pkg;

   localparam int FP_NREQ   = 3;
   localparam int FP_TAG_W  = 5;
   localparam int FP_DST_W  = 5;
   localparam int FP_DATA_W = 32;

   // One CDB broadcast as snooped by the reservation stations and register file.
   typedef struct packed {
      logic [FP_TAG_W-1:0]  tag;
      logic [FP_DST_W-1:0]  dst;
      logic [FP_DATA_W-1:0] val;
   } cdb_t;

   localparam int CDB_W = $bits(cdb_t);

   // Index following idx in a ring of nreq entries.
   function automatic int rr_next(input int idx, input int nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fp_cdb_arbiter_if.sv
// Producer-side request bundle plus the FP CDB broadcast and status outputs.
//
// Handshake: producer i asserts req_valid[i] with stable req_tag/req_dst/req_val
// slices; the transfer happens on the rising clk edge where req_valid[i] and
// req_ready[i] are both high. While req_ready[i] is low the producer must keep
// req_valid[i] and its data unchanged. req_ready never depends on req_valid.
interface fp_cdb_arbiter_if
   import fp_cdb_arbiter_pkg::*;
#(
   parameter int NREQ   = FP_NREQ,
   parameter int TAG_W  = FP_TAG_W,
   parameter int DST_W  = FP_DST_W,
   parameter int DATA_W = FP_DATA_W
) ();

   localparam int PTR_W = $clog2(NREQ);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*TAG_W-1:0]  req_tag;
   logic [NREQ*DST_W-1:0]  req_dst;
   logic [NREQ*DATA_W-1:0] req_val;
   logic [NREQ-1:0]        req_ready;

   logic                   we_FP;
   logic [TAG_W-1:0]       tag_FP;
   logic [DST_W-1:0]       dst_FP;
   logic [DATA_W-1:0]      val_FP;
   logic                   cdb_busy;
   logic                   tag_err;
   logic [PTR_W-1:0]       rr_ptr;   // debug view of the round-robin pointer

   modport master (
      output req_valid, req_tag, req_dst, req_val,
      input  req_ready, we_FP, tag_FP, dst_FP, val_FP, cdb_busy, tag_err, rr_ptr
   );

   modport slave (
      input  req_valid, req_tag, req_dst, req_val,
      output req_ready, we_FP, tag_FP, dst_FP, val_FP, cdb_busy, tag_err, rr_ptr
   );

endinterface

// File: rtl/fp_cdb_arbiter_rr_pick.sv
// Round-robin one-hot picker: first set request at or after ptr_i wins,
// wrapping back to index 0.
module fp_cdb_arbiter_rr_pick
   import fp_cdb_arbiter_pkg::*;
#(
   parameter int NREQ  = FP_NREQ,
   parameter int PTR_W = $clog2(FP_NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             any_o
);

   // Two passes: indices >= ptr first, then the wrapped indices below ptr.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any_o && req_i[i] && (PTR_W'(i) >= ptr_i)) begin
            any_o    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = PTR_W'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!any_o && req_i[i] && (PTR_W'(i) < ptr_i)) begin
            any_o    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = PTR_W'(i);
         end
      end
   end

endmodule

// File: rtl/fp_cdb_arbiter.sv
// FP common data bus arbiter: one holding register per producer, round-robin
// grant of one held result per cycle, registered broadcast stage.
module fp_cdb_arbiter
   import fp_cdb_arbiter_pkg::*;
#(
   parameter int NREQ   = FP_NREQ,
   parameter int TAG_W  = FP_TAG_W,
   parameter int DST_W  = FP_DST_W,
   parameter int DATA_W = FP_DATA_W
) (
   input  logic           clk,
   input  logic           reset,   // asynchronous, active-low
   fp_cdb_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NREQ);

   // Holding registers
   logic [NREQ-1:0]   hv_q, hv_d;
   logic [TAG_W-1:0]  htag_q [NREQ];
   logic [DST_W-1:0]  hdst_q [NREQ];
   logic [DATA_W-1:0] hval_q [NREQ];

   // Arbitration
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]   gnt;
   logic [PTR_W-1:0]  win_idx;
   logic              any_gnt;
   logic [NREQ-1:0]   ready;
   logic [NREQ-1:0]   accept;
   logic [TAG_W-1:0]  win_tag;
   logic [DST_W-1:0]  win_dst;
   logic [DATA_W-1:0] win_val;

   // Broadcast stage and status
   logic              we_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DST_W-1:0]  dst_q;
   logic [DATA_W-1:0] val_q;
   logic              tag_err_q;
   logic              dup;

   fp_cdb_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_i (hv_q),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (win_idx),
      .any_o (any_gnt)
   );

   // A slot is ready when empty or being drained this cycle; a same-edge
   // accept into a granted slot keeps it occupied.
   always_comb begin
      ready    = ~hv_q | gnt;
      accept   = bus.req_valid & ready;
      hv_d     = (hv_q & ~gnt) | accept;
      rr_ptr_d = any_gnt ? PTR_W'(rr_next(int'(win_idx), NREQ)) : rr_ptr_q;
   end

   // Select the granted slot's contents for the broadcast stage.
   always_comb begin
      win_tag = '0;
      win_dst = '0;
      win_val = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_tag = htag_q[i];
            win_dst = hdst_q[i];
            win_val = hval_q[i];
         end
      end
   end

   // Flag any pair of occupied slots carrying the same rename tag.
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         for (int j = i + 1; j < NREQ; j++) begin
            if (hv_q[i] && hv_q[j] && (htag_q[i] == htag_q[j])) begin
               dup = 1'b1;
            end
         end
      end
   end

   // Slot occupancy and round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hv_q     <= '0;
         rr_ptr_q <= '0;
      end else begin
         hv_q     <= hv_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Holding register payloads load on an accepted handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            htag_q[i] <= '0;
            hdst_q[i] <= '0;
            hval_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
               htag_q[i] <= bus.req_tag[i*TAG_W +: TAG_W];
               hdst_q[i] <= bus.req_dst[i*DST_W +: DST_W];
               hval_q[i] <= bus.req_val[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Registered broadcast: pulse per grant, data holds when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q  <= 1'b0;
         tag_q <= '0;
         dst_q <= '0;
         val_q <= '0;
      end else begin
         we_q <= any_gnt;
         if (any_gnt) begin
            tag_q <= win_tag;
            dst_q <= win_dst;
            val_q <= win_val;
         end
      end
   end

   // Sticky duplicate-tag error, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_err_q <= 1'b0;
      end else begin
         tag_err_q <= tag_err_q | dup;
      end
   end

   assign bus.req_ready = ready;
   assign bus.we_FP     = we_q;
   assign bus.tag_FP    = tag_q;
   assign bus.dst_FP    = dst_q;
   assign bus.val_FP    = val_q;
   assign bus.cdb_busy  = |hv_q;
   assign bus.tag_err   = tag_err_q;
   assign bus.rr_ptr    = rr_ptr_q;

endmodule
